// File: rtl/deser_queue_pkg.sv
// Shared types and width helpers for the deserialising receive queue.
package deser_queue_pkg;

  // Deserializer state: collecting bits, or holding a finished word for enqueue
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } fsm_t;

  // Width of a counter that must hold values 0..n-1 (never narrower than 1)
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive
  function automatic int len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // FIFO pointer width: wraps naturally over a power-of-two depth
  function automatic int ptr_w(input int depth);
    return cnt_w(depth);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock-enable tick generator: one-cycle pulse every DIV cycles of clk.
module tick_gen
  import deser_queue_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int            CW   = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Tick is high for the whole cycle in which the count sits at DIV-1
  assign tick = (cnt == LAST);

  // Free-running 0..DIV-1 counter; with DIV=1 it stays at 0 and tick is constant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/deser_queue.sv
// Serial-to-parallel receive path: bit deserializer feeding a DEPTH-entry FIFO.
// Both halves run on clk and advance only on their own tick enables.
module deser_queue
  import deser_queue_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int DESER_DIV = 10,
  parameter int QUEUE_DIV = 100,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       data_in,
  input  logic                       write_in,
  input  logic                       dequeue_in,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(DEPTH+1)-1:0] len_out,
  output logic                       status_out,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int             LW       = len_w(DEPTH);
  localparam int             PW       = ptr_w(DEPTH);
  localparam int             BW       = cnt_w(DATA_W + 1);
  localparam logic [LW-1:0]  FULL_LEN = LW'(DEPTH);
  localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_W - 1);

  logic dtick, qtick;

  tick_gen #(.DIV(DESER_DIV)) u_deser_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (dtick)
  );

  tick_gen #(.DIV(QUEUE_DIV)) u_queue_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (qtick)
  );

  fsm_t              state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bitcnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     len;

  logic take, last_bit, pending, enq, deq;

  // The finished word lives in shreg while in HOLD; pending is just the state.
  // Being a register, a word completing on a queue tick waits for the next one.
  assign pending  = (state == HOLD);
  assign take     = dtick && write_in && (state == COLLECT);
  assign last_bit = take && (bitcnt == LAST_BIT);
  assign deq      = qtick && dequeue_in && (len != '0);
  // A full queue still accepts the word when the same tick pops an entry
  assign enq      = qtick && pending && ((len != FULL_LEN) || deq);

  // Deserializer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= COLLECT;
    else          state <= state_nxt;
  end

  // Next state: HOLD after the last bit of a word, back to COLLECT on enqueue
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (last_bit) state_nxt = HOLD;
      HOLD:    if (enq)      state_nxt = COLLECT;
      default:               state_nxt = COLLECT;
    endcase
  end

  // Outputs decoded from state: accepting bits only while collecting
  always_comb begin
    status_out = (state == COLLECT);
  end

  // Shift register and bit counter; shreg is frozen in HOLD so it is the pending word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else begin
      if (take) begin
        if (MSB_FIRST) shreg <= {shreg[DATA_W-2:0], data_in};
        else           shreg <= {data_in, shreg[DATA_W-1:1]};
      end
      if (enq)       bitcnt <= '0;
      else if (take) bitcnt <= bitcnt + 1'b1;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (dtick && write_in && pending)           overflow  <= 1'b1;
      if (qtick && dequeue_in && (len == '0))     underflow <= 1'b1;
    end
  end

  // FIFO storage and pointers; on full enq+deq the write and read hit the same
  // slot, and the nonblocking read returns the old head as required
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_out <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (deq) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy counter kept separately from the pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) len <= '0;
    else begin
      case ({enq, deq})
        2'b10:   len <= len + 1'b1;
        2'b01:   len <= len - 1'b1;
        default: len <= len;
      endcase
    end
  end

  assign len_out = len;

endmodule

// File: tb/tb_deser_queue.sv
// Directed bench for deser_queue: one MSB-first and one LSB-first instance
// share all inputs; expected values are hand-computed constants.
module tb_deser_queue;

  localparam int DD = 10;
  localparam int QD = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       data_in = 1'b0;
  logic       write_in = 1'b0;
  logic       dequeue_in = 1'b0;

  logic [7:0] data_out, data_out_l;
  logic [3:0] len_out, len_out_l;
  logic       status_out, status_out_l;
  logic       overflow, overflow_l;
  logic       underflow, underflow_l;

  int n_chk = 0;
  int n_err = 0;

  int dcnt, qcnt;

  always #5 clk = ~clk;

  deser_queue #(.DATA_W(8), .DEPTH(8), .DESER_DIV(DD), .QUEUE_DIV(QD), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .write_in   (write_in),
    .dequeue_in (dequeue_in),
    .data_out   (data_out),
    .len_out    (len_out),
    .status_out (status_out),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  deser_queue #(.DATA_W(8), .DEPTH(8), .DESER_DIV(DD), .QUEUE_DIV(QD), .MSB_FIRST(1'b0)) dut_lsb (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .write_in   (write_in),
    .dequeue_in (dequeue_in),
    .data_out   (data_out_l),
    .len_out    (len_out_l),
    .status_out (status_out_l),
    .overflow   (overflow_l),
    .underflow  (underflow_l)
  );

  // Bench-side tick schedule: first tick DIV cycles after reset release
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dcnt <= 0;
      qcnt <= 0;
    end else begin
      dcnt <= (dcnt == DD - 1) ? 0 : dcnt + 1;
      qcnt <= (qcnt == QD - 1) ? 0 : qcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one valid bit across the next deser tick edge
  task automatic send_bit(input logic b);
    while (dcnt != DD - 1) @(negedge clk);
    data_in  = b;
    write_in = 1'b1;
    @(negedge clk);
    write_in = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  // Let one queue tick pass, optionally requesting a pop; returns one cycle after it
  task automatic qtick(input logic pop);
    while (qcnt != QD - 1) @(negedge clk);
    dequeue_in = pop;
    @(negedge clk);
    dequeue_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_w;
    repeat (2) @(negedge clk);
    chk("rst_data", data_out, 8'h00);
    chk("rst_len", len_out, 4'd0);
    chk("rst_status", status_out, 1'b1);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_udf", underflow, 1'b0);
    reset_n = 1'b1;

    // Single word 0xA5
    send_word(8'hA5);
    chk("w1_status_hold", status_out, 1'b0);
    qtick(1'b0);
    chk("w1_len", len_out, 4'd1);
    chk("w1_status_rise", status_out, 1'b1);
    qtick(1'b1);
    chk("w1_data", data_out, 8'hA5);
    chk("w1_len_pop", len_out, 4'd0);

    // Bit order: stream 1,0,0,0,0,0,0,0
    send_word(8'h80);
    qtick(1'b0);
    qtick(1'b1);
    chk("order_msb", data_out, 8'h80);
    chk("order_lsb", data_out_l, 8'h01);

    // Fill to DEPTH with 0x00..0x07
    for (int k = 0; k < 8; k++) begin
      send_word(8'(k));
      qtick(1'b0);
    end
    chk("full_len", len_out, 4'd8);
    send_word(8'h08);
    qtick(1'b0);
    chk("full_status", status_out, 1'b0);
    chk("full_len_blocked", len_out, 4'd8);
    chk("full_ovf_before", overflow, 1'b0);
    send_bit(1'b1);
    chk("full_ovf", overflow, 1'b1);
    qtick(1'b1);
    chk("full_pop_data", data_out, 8'h00);
    chk("full_pop_len", len_out, 4'd8);
    chk("full_pop_status", status_out, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      exp_w = 8'(k);
      qtick(1'b1);
      chk($sformatf("drain_%0d", k), data_out, exp_w);
    end
    chk("drain_len", len_out, 4'd0);

    // Underflow on empty queue
    chk("udf_before", underflow, 1'b0);
    qtick(1'b1);
    chk("udf_flag", underflow, 1'b1);
    chk("udf_len", len_out, 4'd0);
    chk("udf_data_hold", data_out, 8'h08);

    // Asynchronous reset mid-run: outputs clear immediately
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("arst_data", data_out, 8'h00);
    chk("arst_len", len_out, 4'd0);
    chk("arst_status", status_out, 1'b1);
    chk("arst_ovf", overflow, 1'b0);
    chk("arst_udf", underflow, 1'b0);
    chk("arst_data_lsb", data_out_l, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset after 5 bits discards the partial word
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    do_reset();
    send_word(8'h3C);
    qtick(1'b0);
    chk("mid_len", len_out, 4'd1);
    qtick(1'b1);
    chk("mid_data", data_out, 8'h3C);
    chk("mid_len_pop", len_out, 4'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/deser_queue.md
# deser_queue

Single-clock, parametrised serial-to-parallel receive path: deserialises a bit stream into DATA_W-bit words and buffers them in a DEPTH-entry FIFO drained by a consumer strobe. Successor to the split deserializer/queue pair. The two derived clocks are replaced by clock-enable ticks on one clock, and the hand-off between the deserializer and the queue is made explicit. Adds configurable bit order and sticky overflow/underflow flags. Sits between the serial front end and the byte consumer.

## Interface
- DATA_W, 8, word width in bits (≥2)
- DEPTH, 8, FIFO entries (power of two, ≥2)
- DESER_DIV, 10, clk cycles per deserializer tick (≥1)
- QUEUE_DIV, 100, clk cycles per queue tick (≥1)
- MSB_FIRST, 1, 1: first received bit lands in bit DATA_W-1; 0: first received bit lands in bit 0
- clk  in  1  single system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- data_in  in  1  serial data bit, sampled on deser tick
- write_in  in  1  data_in valid qualifier, sampled on deser tick
- dequeue_in  in  1  pop request, sampled on queue tick
- data_out  out  DATA_W  last popped word
- len_out  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- status_out  out  1  1 = deserializer accepting bits; 0 = word held awaiting enqueue
- overflow  out  1  sticky: a valid bit arrived while status_out=0
- underflow  out  1  sticky: pop requested while empty

## Operation
- Tick generators: independent counters 0..DIV-1. Tick fires in the cycle the count equals DIV-1, then the count wraps to 0. DIV=1 gives a tick every cycle.
- Deserializer FSM, 2 states:
  - COLLECT (status_out=1): on deser tick with write_in=1, shift data_in in per MSB_FIRST and increment the bit count. When the DATA_W-th bit is taken, latch the word as pending and go to HOLD. Ticks with write_in=0 are ignored.
  - HOLD (status_out=0): wait for enqueue. On deser tick with write_in=1, drop the bit and set overflow. On enqueue, clear the bit count and go to COLLECT.
- Queue, on queue tick only:
  - enq = pending && (len<DEPTH || deq)
  - deq = dequeue_in && len>0
  - dequeue_in with len=0: set underflow, no pop.
- Enqueue when full is permitted only if a pop occurs on the same tick. len_out is then unchanged.
- data_out loads the head entry on pop and holds otherwise.
- Read/write pointers are log2(DEPTH) bits and wrap naturally. Occupancy is kept in its own counter.
- overflow and underflow clear only on reset.

## Timing
- Reset values:
  - data_out=0, len_out=0, status_out=1, overflow=0, underflow=0
  - both tick counters=0, bit count=0, FSM in COLLECT
- First deser tick occurs DESER_DIV cycles after reset_n deasserts. First queue tick occurs QUEUE_DIV cycles after.
- Status/occupancy latency:
  - status_out falls in the cycle after the tick that takes the last bit.
  - status_out rises in the cycle after the enqueue tick.
  - len_out updates in the cycle after the queue tick.
- Enqueue tick: pending is registered, so a word completing on a cycle where both ticks coincide enqueues on the following queue tick, not the same one.
- Pop latency: data_out valid one cycle after the popping queue tick.
- Simultaneous events:
  - enq+deq on one tick: len unchanged, data_out = old head.
  - Pop of the only entry while a new one enqueues: data_out = old entry, len stays 1.
- Reset mid-word: partial bits discarded, FIFO contents discarded. No output glitch beyond reset values.

## Structure
- Package deser_queue_pkg:
  - fsm state enum (COLLECT, HOLD)
  - localparams for len/pointer width derivation
- Sub-module tick_gen (parameter DIV; ports clk, reset_n, tick), instantiated twice.
- FIFO storage: flat register array, no inferred RAM.

## Test plan
Defaults are used unless stated.
1. Reset: assert reset_n=0 mid-run → data_out=0x00, len_out=0, status_out=1, overflow=0, underflow=0 immediately (asynchronous).
2. Single word: shift bits 1,0,1,0,0,1,0,1 on 8 deser ticks with write_in=1 → status_out=0 after tick 8; next queue tick → len_out=1, status_out=1. Pop → data_out=0xA5, len_out=0.
3. Bit order: MSB_FIRST=0, bit stream 1,0,0,0,0,0,0,0 → popped data_out=0x01. With MSB_FIRST=1, the same stream gives 0x80.
4. Full and overflow:
   - Enqueue 8 words 0x00..0x07 → len_out=8.
   - 9th word 0x08 completes → status_out stays 0.
   - One extra valid bit → overflow=1.
   - Pop → data_out=0x00, 0x08 enqueued on the same tick, len_out stays 8.
   - Drain → data_out 0x01..0x08 in order.
5. Underflow: dequeue_in=1 on empty queue → underflow=1, len_out=0, data_out holds its previous value.
6. Reset mid-word: reset after 5 bits, then shift 0x3C → the single queued word is 0x3C, len_out=1.
